// File: rtl/freq_gen_if.sv
// freq_gen_if: control, settings and waveform/status signals of the frequency generator
interface freq_gen_if;
  logic       start_i;
  logic       stop_i;
  logic [3:0] bcd3_i;
  logic [3:0] bcd2_i;
  logic [3:0] bcd1_i;
  logic [3:0] bcd0_i;
  logic [1:0] dec_i;
  logic       sig_o;
  logic       run_o;
  logic       ready_o;
  logic       err_o;
  modport master (output start_i, stop_i, bcd3_i, bcd2_i, bcd1_i, bcd0_i, dec_i,
                  input  sig_o, run_o, ready_o, err_o);
  modport slave  (input  start_i, stop_i, bcd3_i, bcd2_i, bcd1_i, bcd0_i, dec_i,
                  output sig_o, run_o, ready_o, err_o);
endinterface

// File: rtl/freq_gen.sv
// freq_gen: BCD-programmed square-wave generator with serial BCD-to-binary and restoring divide
module freq_gen #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DIV_W  = 36
) (
  input logic      clk,
  input logic      rst,
  freq_gen_if.slave bus
);
  localparam int unsigned BW = $clog2(DIV_W);
  localparam logic [63:0] H  = 64'(CLK_HZ / 2);
  typedef enum logic [1:0] {IDLE, CONV, DIV, RUN} state_t;
  state_t            state_q, state_d;
  logic [15:0]       dig_q, dig_d;
  logic [1:0]        dec_q, dec_d;
  logic [13:0]       acc_q, acc_d, acc_nx;
  logic [13:0]       rem_q, rem_d, rem_nx;
  logic [DIV_W-1:0]  quo_q, quo_d, quo_nx, cnt_q, cnt_d, dvd;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sig_q, sig_d, err_q, err_d;
  logic [14:0]       sh;
  logic              ge, bad, take;
  assign bad    = (bus.bcd3_i > 4'd9) | (bus.bcd2_i > 4'd9) | (bus.bcd1_i > 4'd9) | (bus.bcd0_i > 4'd9);
  assign take   = bus.start_i & ~bus.stop_i & (state_q == IDLE | state_q == RUN);
  assign acc_nx = 14'(acc_q * 14'd10) + {10'd0, dig_q[15:12]};
  assign sh     = {rem_q, quo_q[DIV_W-1]};
  assign ge     = sh >= {1'b0, acc_q};
  assign rem_nx = ge ? 14'(sh - {1'b0, acc_q}) : sh[13:0];
  assign quo_nx = {quo_q[DIV_W-2:0], ge};
  assign dvd    = DIV_W'(dec_q == 2'd0 ? H : dec_q == 2'd1 ? H * 64'd10 :
                         dec_q == 2'd2 ? H * 64'd100 : H * 64'd1000);
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    dec_d   = dec_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sig_d   = sig_q;
    err_d   = err_q;
    case (state_q)
      CONV: begin
        acc_d = acc_nx;
        dig_d = {dig_q[11:0], 4'h0};
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(3)) begin
          bit_d   = '0;
          state_d = acc_nx == '0 ? IDLE : DIV;
          err_d   = acc_nx == '0;
          quo_d   = dvd;
          rem_d   = '0;
        end
      end
      DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(DIV_W - 1)) begin
          bit_d   = '0;
          state_d = quo_nx == '0 ? IDLE : RUN;
          err_d   = quo_nx == '0;
          cnt_d   = quo_nx - DIV_W'(1);
          sig_d   = 1'b0;
        end
      end
      RUN: begin
        cnt_d = cnt_q == '0 ? quo_q - DIV_W'(1) : cnt_q - DIV_W'(1);
        sig_d = cnt_q == '0 ? ~sig_q : sig_q;
      end
      default: ;
    endcase
    if (take) begin
      state_d = bad ? IDLE : CONV;
      dig_d   = {bus.bcd3_i, bus.bcd2_i, bus.bcd1_i, bus.bcd0_i};
      dec_d   = bus.dec_i;
      acc_d   = '0;
      bit_d   = '0;
      sig_d   = 1'b0;
      err_d   = bad;
    end
    if (bus.stop_i) begin
      state_d = IDLE;
      sig_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dig_q   <= '0;
      dec_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sig_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      dec_q   <= dec_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
    end
  end
  assign bus.sig_o   = sig_q;
  assign bus.run_o   = state_q == RUN;
  assign bus.ready_o = state_q == IDLE;
  assign bus.err_o   = err_q;
endmodule
